// File: rtl/cia_pkg.sv
// Shared CIA types: bus-host access FSM states, latched request record and
// the default /RES pulse length.
package cia_pkg;

    localparam int RES_CYCLES_MIN = 10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LO,
        LO,
        HI
    } host_state_t;

    typedef struct packed {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
    } host_req_t;

endpackage

// File: rtl/cia_phi2_gen.sv
// PHI2 bus clock generator: 50% duty, 2*HALF_PERIOD clk per period, with
// one-clk strobes for the cycles in which phi2 is registered high or low.
module cia_phi2_gen #(
    parameter int HALF_PERIOD = 8
) (
    input  logic clk,
    input  logic rst,
    output logic phi2,
    output logic phi_up,
    output logic phi_dn
);

    localparam int CW = $clog2(HALF_PERIOD);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap   = (cnt == CW'(HALF_PERIOD - 1));
    assign phi_up = wrap & ~phi2;
    assign phi_dn = wrap & phi2;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            phi2 <= 1'b0;
        end else if (wrap) begin
            cnt  <= '0;
            phi2 <= ~phi2;
        end else begin
            cnt  <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/cia_bus_host.sv
// CIA bus initiator: single register accesses aligned to PHI2, /RES pulse
// sequencing and /IRQ synchronisation for an FPGA-side requester.
module cia_bus_host
    import cia_pkg::*;
#(
    parameter int HALF_PERIOD = 8,
    parameter int RES_CYCLES  = RES_CYCLES_MIN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       req_we,
    input  logic [3:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       ready,
    output logic       ack,
    output logic [7:0] rdata,
    input  logic       bus_reset,
    output logic       irq,
    output logic       irq_fall,
    output logic       phi2,
    output logic       cs_n,
    output logic       r_w_n,
    output logic [3:0] addr,
    output logic [7:0] data_o,
    output logic       data_oe,
    input  logic [7:0] data_i,
    output logic       res_n,
    input  logic       irq_n
);

    localparam int RW = $clog2(RES_CYCLES + 1);

    logic          phi_up;
    logic          phi_dn;
    host_state_t   state;
    host_state_t   state_nx;
    host_req_t     req_q;
    logic [RW-1:0] res_cnt;
    logic          res_pend;
    logic          do_res;
    logic          accept;
    logic          irq_s1;
    logic          irq_s2;

    cia_phi2_gen #(.HALF_PERIOD(HALF_PERIOD)) u_phi2 (
        .clk    (clk),
        .rst    (rst),
        .phi2   (phi2),
        .phi_up (phi_up),
        .phi_dn (phi_dn)
    );

    // A bus reset requested mid-access waits in res_pend until the FSM is idle.
    assign do_res = (bus_reset | res_pend) & (state == IDLE);
    assign accept = ready & req & ~do_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch is inferred.
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = WAIT_LO;
            WAIT_LO: if (phi_dn) state_nx = LO;
            LO:      if (phi_up) state_nx = HI;
            HI:      if (phi_dn) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bus strobes decode straight from state, so rst releases them at once.
    always_comb begin
        cs_n    = 1'b1;
        r_w_n   = 1'b1;
        data_oe = 1'b0;
        data_o  = '0;
        if (state == LO || state == HI) begin
            cs_n  = 1'b0;
            r_w_n = ~req_q.we;
        end
        if (state == HI && req_q.we) begin
            data_oe = 1'b1;
            data_o  = req_q.wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '0;
            addr  <= '0;
            ready <= 1'b0;
            ack   <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= (state == IDLE) && res_n && !accept && !do_res;
            ack   <= (state == HI) && phi_dn;
            if (accept)
                req_q <= '{we: req_we, addr: req_addr, wdata: req_wdata};
            if (state == WAIT_LO && phi_dn)
                addr <= req_q.addr;
            if (state == HI && phi_dn && !req_q.we)
                rdata <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_cnt  <= RW'(RES_CYCLES);
            res_n    <= 1'b0;
            res_pend <= 1'b0;
        end else if (do_res) begin
            res_cnt  <= RW'(RES_CYCLES);
            res_n    <= 1'b0;
            res_pend <= 1'b0;
        end else begin
            if (bus_reset)
                res_pend <= 1'b1;
            if (phi_dn && res_cnt != '0) begin
                res_cnt <= res_cnt - RW'(1);
                if (res_cnt == RW'(1))
                    res_n <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_s1   <= 1'b1;
            irq_s2   <= 1'b1;
            irq_fall <= 1'b0;
        end else begin
            irq_s1   <= irq_n;
            irq_s2   <= irq_s1;
            irq_fall <= irq_s2 & ~irq_s1;
        end
    end

    assign irq = ~irq_s2;

endmodule

// File: tb/tb_cia_bus_host.sv
// Directed bench for cia_bus_host: reset pulse, read/write cycles, back-to-back
// and ignored requests, reset interplay and the /IRQ synchroniser.
module tb_cia_bus_host;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       req_we;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       ready;
    logic       ack;
    logic [7:0] rdata;
    logic       bus_reset;
    logic       irq;
    logic       irq_fall;
    logic       phi2;
    logic       cs_n;
    logic       r_w_n;
    logic [3:0] addr;
    logic [7:0] data_o;
    logic       data_oe;
    logic [7:0] data_i;
    logic       res_n;
    logic       irq_n;

    int n_checks = 0;
    int n_fails  = 0;
    int e        = 0;

    always #5 clk = ~clk;

    cia_bus_host #(.HALF_PERIOD(8), .RES_CYCLES(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ready     (ready),
        .ack       (ack),
        .rdata     (rdata),
        .bus_reset (bus_reset),
        .irq       (irq),
        .irq_fall  (irq_fall),
        .phi2      (phi2),
        .cs_n      (cs_n),
        .r_w_n     (r_w_n),
        .addr      (addr),
        .data_o    (data_o),
        .data_oe   (data_oe),
        .data_i    (data_i),
        .res_n     (res_n),
        .irq_n     (irq_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, e, obs, exp);
        end
    endtask

    // Advance to the falling clk edge that follows rising edge t after release.
    task automatic goto(input int t);
        while (e < t) begin
            @(negedge clk);
            e++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acks;
        int lows;
        int falls;

        rst = 1'b1; req = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        bus_reset = 1'b0; data_i = '0; irq_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_phi2", phi2, 0);       check("rst_cs_n", cs_n, 1);
        check("rst_r_w_n", r_w_n, 1);     check("rst_addr", addr, 0);
        check("rst_data_o", data_o, 0);   check("rst_data_oe", data_oe, 0);
        check("rst_res_n", res_n, 0);     check("rst_ready", ready, 0);
        check("rst_ack", ack, 0);         check("rst_rdata", rdata, 0);
        check("rst_irq", irq, 0);         check("rst_irq_fall", irq_fall, 0);
        rst = 1'b0; e = 0;

        goto(7);   check("phi2_lo", phi2, 0);
        goto(8);   check("phi2_rise", phi2, 1);
        goto(16);  check("phi2_fall", phi2, 0);
        goto(159); check("res_low_159", res_n, 0); check("ready_in_res", ready, 0);
        goto(160); check("res_high_160", res_n, 1); check("ready_lag", ready, 0);
        goto(161); check("ready_after_res", ready, 1);

        // Write 0x5A to register 4
        req = 1'b1; req_we = 1'b1; req_addr = 4'h4; req_wdata = 8'h5A;
        goto(162); check("wr_accept_ready", ready, 0); check("wr_wait_cs", cs_n, 1);
        req = 1'b0;
        goto(175); check("wr_pre_cs", cs_n, 1);
        goto(176); check("wr_cs", cs_n, 0); check("wr_rwn", r_w_n, 0);
        check("wr_addr", addr, 4'h4); check("wr_lo_oe", data_oe, 0); check("wr_lo_do", data_o, 0);
        goto(183); check("wr_lo_end_oe", data_oe, 0);
        goto(184); check("wr_hi_oe", data_oe, 1); check("wr_hi_do", data_o, 8'h5A);
        goto(191); check("wr_pre_ack", ack, 0);
        goto(192); check("wr_ack", ack, 1); check("wr_rel_cs", cs_n, 1);
        check("wr_rel_oe", data_oe, 0); check("wr_rel_rwn", r_w_n, 1);
        check("wr_addr_hold", addr, 4'h4); check("wr_rdata_keep", rdata, 0);
        check("wr_ack_ready", ready, 0);
        goto(193); check("wr_ack_pulse", ack, 0); check("wr_ready_back", ready, 1);

        // Read register 0xD, bus returns 0x81 in the high phase
        req = 1'b1; req_we = 1'b0; req_addr = 4'hD; req_wdata = 8'h00;
        goto(194); req = 1'b0;
        goto(208); check("rd_cs", cs_n, 0); check("rd_rwn_lo", r_w_n, 1); check("rd_addr", addr, 4'hD);
        goto(216); check("rd_hi_oe", data_oe, 0); check("rd_rwn_hi", r_w_n, 1);
        data_i = 8'h81;
        goto(224); check("rd_ack", ack, 1); check("rd_rdata", rdata, 8'h81); check("rd_rel_cs", cs_n, 1);
        data_i = 8'h00;
        goto(225); check("rd_ready", ready, 1); check("rd_rdata_hold", rdata, 8'h81);

        // Back-to-back writes, then a request held while busy
        req = 1'b1; req_we = 1'b1; req_addr = 4'h4; req_wdata = 8'h11;
        goto(226); check("b2b1_accept", ready, 0);
        req = 1'b0;
        goto(240); check("b2b1_cs", cs_n, 0); check("b2b1_addr", addr, 4'h4);
        goto(248); check("b2b1_do", data_o, 8'h11);
        goto(256); check("b2b1_ack", ack, 1);
        goto(257); check("b2b_ready", ready, 1);
        req = 1'b1; req_addr = 4'h5; req_wdata = 8'h22;
        goto(258); check("b2b2_accept", ready, 0);
        req_addr = 4'h6; req_wdata = 8'h33;
        goto(271); check("b2b2_pre_cs", cs_n, 1);
        goto(272); check("b2b2_cs", cs_n, 0); check("b2b2_addr", addr, 4'h5);
        goto(280); check("b2b2_do", data_o, 8'h22);
        goto(288); check("b2b2_ack", ack, 1);
        req = 1'b0;
        acks = 0; lows = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); e++;
            acks += int'(ack);
            lows += int'(!cs_n);
        end
        check("ign_no_ack", acks, 0); check("ign_no_cs", lows, 0);
        check("ign_addr", addr, 4'h5); check("ign_ready", ready, 1);

        // bus_reset during a write is deferred until the ack
        req = 1'b1; req_we = 1'b1; req_addr = 4'h7; req_wdata = 8'hA5;
        goto(297); req = 1'b0;
        goto(304); check("br_cs", cs_n, 0);
        goto(306); bus_reset = 1'b1;
        goto(307); bus_reset = 1'b0; check("br_defer_res", res_n, 1);
        goto(312); check("br_hi_oe", data_oe, 1); check("br_hi_res", res_n, 1);
        goto(320); check("br_ack", ack, 1); check("br_ack_res", res_n, 1);
        goto(321); check("br_res_low", res_n, 0); check("br_ready", ready, 0);
        goto(479); check("br_res_479", res_n, 0);
        goto(480); check("br_res_480", res_n, 1);
        goto(481); check("br_ready_back", ready, 1);

        // rst asserted while the access is in its high phase
        req = 1'b1; req_we = 1'b1; req_addr = 4'h2; req_wdata = 8'h3C;
        goto(482); req = 1'b0;
        goto(506); check("rh_cs", cs_n, 0); check("rh_oe", data_oe, 1);
        #2 rst = 1'b1;
        #1;
        check("rh_cs_rel", cs_n, 1); check("rh_oe_rel", data_oe, 0);
        check("rh_rwn", r_w_n, 1);   check("rh_do", data_o, 0);
        check("rh_res", res_n, 0);   check("rh_phi2", phi2, 0);
        check("rh_addr", addr, 0);   check("rh_ready", ready, 0);
        acks = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); e++;
            acks += int'(ack);
        end
        check("rh_no_ack", acks, 0);
        rst = 1'b0; e = 0;
        goto(159); check("rr_res_159", res_n, 0);
        goto(160); check("rr_res_160", res_n, 1);
        goto(161); check("rr_ready", ready, 1);

        // bus_reset while idle drops res_n on the next clk
        bus_reset = 1'b1;
        goto(162); bus_reset = 1'b0;
        check("bi_res", res_n, 0); check("bi_ready", ready, 0);

        // /IRQ synchroniser
        #2 irq_n = 1'b0;
        falls = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); e++;
            falls += int'(irq_fall);
        end
        check("irq_assert", irq, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); e++;
            falls += int'(irq_fall);
        end
        check("irq_fall_once", falls, 1); check("irq_held", irq, 1);
        #2 irq_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); e++;
            falls += int'(irq_fall);
        end
        check("irq_release", irq, 0); check("irq_no_rise_pulse", falls, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/cia_bus_host.md
Name: cia_bus_host

Overview:
- Bus initiator for the CIA register interface: generates PHI2 and performs single register read/write cycles on CS_n, R/W_n, ADDR and DATA for an FPGA-side requester.
- Drives /RES with a minimum-length pulse and synchronises /IRQ back to the requester.
- Sits opposite cia_core: used in self-test builds and bench top-levels, and for driving an external 6526/8520 from the FPGA.

Parameters:
- HALF_PERIOD, 8, clk cycles per PHI2 phase (low or high); legal range >= 2.
- RES_CYCLES, 10, PHI2 cycles /RES is held low per bus reset; legal range >= 1.

Ports:
- clk  in  1  FPGA clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  access request, sampled only when ready=1.
- req_we  in  1  1=write, 0=read.
- req_addr  in  4  register address.
- req_wdata  in  8  write data.
- ready  out  1  host can accept a request.
- ack  out  1  one-clk pulse: access complete.
- rdata  out  8  read data, valid with ack, held until next ack.
- bus_reset  in  1  pulse: issue a /RES sequence.
- irq  out  1  synchronised /IRQ asserted (active-high).
- irq_fall  out  1  one-clk pulse on /IRQ assertion.
- phi2  out  1  bus clock.
- cs_n  out  1  chip select.
- r_w_n  out  1  1=read.
- addr  out  4  bus address.
- data_o  out  8  bus write data.
- data_oe  out  1  data bus drive enable.
- data_i  in  8  bus read data.
- res_n  out  1  bus reset.
- irq_n  in  1  asynchronous /IRQ from the CIA.

Behaviour:
- Reset values: phi2=0, cs_n=1, r_w_n=1, addr=0, data_o=0, data_oe=0, res_n=0, ready=0, ack=0, rdata=0, irq=0, irq_fall=0. Phase counter is 0; the reset counter is loaded with RES_CYCLES.
- PHI2 generation:
  - The phase counter counts 0..HALF_PERIOD-1 and phi2 toggles on wrap, giving a period of 2*HALF_PERIOD clk cycles and a 50% duty cycle.
  - phi_up and phi_dn are internal one-clk strobes, asserted in the cycle phi2 is registered 0->1 and 1->0 respectively.
  - PHI2 runs continuously after reset, including during /RES.
- /RES sequencing:
  - res_n is low while the reset counter is non-zero; the counter decrements on each phi_dn.
  - res_n goes 1 on the phi_dn at which the counter reaches 0.
  - rst therefore yields RES_CYCLES full PHI2 cycles of /RES low.
  - bus_reset while idle reloads the counter and drops res_n the next clk.
  - bus_reset during an access is deferred until that access acks.
  - ready is 0 while res_n=0.
- Access FSM states: IDLE, WAIT_LO, LO, HI.
  - IDLE: ready=1 when res_n=1. On req, latch we/addr/wdata, set ready=0 and go to WAIT_LO.
  - WAIT_LO: on phi_dn, drive addr, r_w_n=~we and cs_n=0, then go to LO. The access therefore starts at the beginning of a low phase; worst-case start latency is 2*HALF_PERIOD clk.
  - LO: on phi_up, go to HI. For a write, data_o=wdata and data_oe=1 from the same edge.
  - HI: on phi_dn, capture data_i into rdata (reads only; the value sampled is the one present in that clk, before the outputs change). In the same edge, release cs_n=1, r_w_n=1 and data_oe=0, pulse ack, and return to IDLE. ready reasserts the cycle after ack.
  - Accept-to-ack time is 2..4*HALF_PERIOD clk.
  - Writes leave rdata unchanged.
  - addr holds its last value after release.
- Back-to-back requests: req asserted in the ready cycle after ack starts at the next phi_dn. At most one access per two PHI2 cycles is guaranteed; no pipelining.
- req while ready=0 is ignored, not queued.
- /IRQ path:
  - irq_n passes through a 2-flop synchroniser; irq = ~synchronised value.
  - irq_fall pulses for one clk on a synchronised 1->0 transition.
  - Latency from an irq_n edge to irq is 2-3 clk.
- rst mid-access: all outputs return to reset values immediately (asynchronous). No ack is issued and the /RES sequence restarts.

Decomposition:
- Shared cia package gains:
  - host_state_t enum (IDLE, WAIT_LO, LO, HI).
  - host_req_t struct {we, addr[3:0], wdata[7:0]}.
  - Constant RES_CYCLES_MIN=10.
- Sub-module cia_phi2_gen (parameter HALF_PERIOD; outputs phi2, phi_up, phi_dn); reusable by bench top-levels.
- FSM, /RES counter and IRQ synchroniser stay in cia_bus_host.

Test Plan:
- Reset: hold rst 3 clk, release, HALF_PERIOD=8. Required: res_n low exactly 10 PHI2 cycles (160 clk) after release; ready=1 the clk after res_n rises.
- Write: req_we=1, addr=4, wdata=0x5A. Required: cs_n=0 for one PHI2 cycle starting at phi2 fall; data_oe=1 and data_o=0x5A only in the high phase; ack on the closing fall; a cia_core instance reads TA latch low = 0x5A.
- Read: req_we=0, addr=0xD, data_i=0x81 in the high phase and 0x00 after the fall. Required: rdata=0x81 with ack; r_w_n=1 throughout.
- Back-to-back and ignored requests: writes to 0x4 and 0x5 issued on consecutive ready cycles, then req held during busy. Required: two accesses on successive-but-one PHI2 cycles; the extra req is dropped and no third ack appears.
- Reset interplay: bus_reset mid-write. Required: the write completes with ack, then res_n=0 for 10 PHI2 cycles. rst asserted during HI: cs_n=1 and data_oe=0 at once, no ack.
- IRQ: irq_n 1->0 asynchronously. Required: irq=1 within 3 clk and irq_fall pulses once; irq_n 0->1 gives irq=0 with no pulse.
